// File: rtl/fifo_hex_drain_if.sv
// fifo_hex_drain_if
// Groups the FIFO read side, the UART character handshake and the status/control
// signals of fifo_hex_drain.
//   slave  : the drain block itself (takes i_* in, drives o_*).
//   master : the environment (FIFO, UART transmitter, control).
// Signals:
//   i_enable      drain enable
//   i_flush       request to terminate a partial line when the FIFO is empty
//   o_fifo_ren    FIFO read strobe, data valid one cycle later
//   i_fifo_data   FIFO read data
//   i_fifo_empty  FIFO empty flag
//   i_fifo_full   FIFO full flag
//   i_ovf_clr     clear of the sticky overflow flag
//   o_tx_data     ASCII character to the transmitter
//   o_tx_valid    character valid
//   i_tx_ready    transmitter accepts the character
//   o_busy        drain is mid-sequence
//   o_ovf         sticky "FIFO was full" flag
interface fifo_hex_drain_if;
  logic       i_enable;
  logic       i_flush;
  logic       o_fifo_ren;
  logic [7:0] i_fifo_data;
  logic       i_fifo_empty;
  logic       i_fifo_full;
  logic       i_ovf_clr;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic       i_tx_ready;
  logic       o_busy;
  logic       o_ovf;

  modport slave (
    input  i_enable, i_flush, i_fifo_data, i_fifo_empty, i_fifo_full,
           i_ovf_clr, i_tx_ready,
    output o_fifo_ren, o_tx_data, o_tx_valid, o_busy, o_ovf
  );

  modport master (
    output i_enable, i_flush, i_fifo_data, i_fifo_empty, i_fifo_full,
           i_ovf_clr, i_tx_ready,
    input  o_fifo_ren, o_tx_data, o_tx_valid, o_busy, o_ovf
  );
endinterface

// File: rtl/fifo_hex_drain.sv
// fifo_hex_drain
// Reads bytes one at a time from a FIFO and prints each as two uppercase hex
// digits to a UART transmitter, separated by spaces, with CR/LF after every
// LINE_BYTES bytes (or on a flush request once the FIFO has run dry).
// Ports:
//   i_clk    rising-edge clock
//   i_res_n  asynchronous active-low reset
//   bus      fifo_hex_drain_if.slave (FIFO read, tx handshake, status)
// Parameter:
//   LINE_BYTES  bytes per text line, 1..255
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for data (or a flush of a partial line)
// RD    | FIFO read strobe asserted for one cycle
// LAT   | FIFO data valid, captured into byte register
// HI    | sending hex digit of the upper nibble
// LO    | sending hex digit of the lower nibble
// SEP   | sending space between bytes
// CR    | sending carriage return
// LF    | sending line feed, line count cleared on acceptance
module fifo_hex_drain #(
  parameter int LINE_BYTES = 16
) (
  input  logic           i_clk,
  input  logic           i_res_n,
  fifo_hex_drain_if.slave bus
);

  localparam int            CW   = $clog2(LINE_BYTES + 1);
  localparam logic [CW-1:0] LAST = CW'(LINE_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_LAT, S_HI, S_LO, S_SEP, S_CR, S_LF
  } state_t;

  state_t        state;
  logic [CW-1:0] line_cnt;
  logic [7:0]    byte_q;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          ren;
  logic          busy;
  logic          ovf;

  function automatic logic [7:0] to_hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Outputs are registered alongside the state: each transition loads the
  // output values belonging to the state being entered.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      state    <= S_IDLE;
      line_cnt <= '0;
      byte_q   <= 8'h00;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      ren      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.i_enable && !bus.i_fifo_empty) begin
            state <= S_RD;
            ren   <= 1'b1;
            busy  <= 1'b1;
          end else if (bus.i_flush && bus.i_fifo_empty && (line_cnt != '0)) begin
            state    <= S_CR;
            tx_data  <= 8'h0D;
            tx_valid <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_RD: begin
          ren   <= 1'b0;
          state <= S_LAT;
        end
        S_LAT: begin
          // HI must present its digit on entry, so it is taken straight from
          // the FIFO data rather than from the byte register being loaded.
          byte_q   <= bus.i_fifo_data;
          tx_data  <= to_hex(bus.i_fifo_data[7:4]);
          tx_valid <= 1'b1;
          state    <= S_HI;
        end
        S_HI: begin
          if (bus.i_tx_ready) begin
            tx_data <= to_hex(byte_q[3:0]);
            state   <= S_LO;
          end else begin
            tx_data <= to_hex(byte_q[7:4]);
          end
        end
        S_LO: begin
          if (bus.i_tx_ready) begin
            if (line_cnt == LAST) begin
              tx_data <= 8'h0D;
              state   <= S_CR;
            end else begin
              line_cnt <= line_cnt + CW'(1);
              tx_data  <= 8'h20;
              state    <= S_SEP;
            end
          end
        end
        S_SEP: begin
          if (bus.i_tx_ready) begin
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        end
        S_CR: begin
          if (bus.i_tx_ready) begin
            tx_data <= 8'h0A;
            state   <= S_LF;
          end
        end
        S_LF: begin
          if (bus.i_tx_ready) begin
            line_cnt <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: begin
          state    <= S_IDLE;
          tx_valid <= 1'b0;
          ren      <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overflow: a full flag in the same cycle as a clear still sets it.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      ovf <= 1'b0;
    end else if (bus.i_fifo_full) begin
      ovf <= 1'b1;
    end else if (bus.i_ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  assign bus.o_fifo_ren = ren;
  assign bus.o_tx_data  = tx_data;
  assign bus.o_tx_valid = tx_valid;
  assign bus.o_busy     = busy;
  assign bus.o_ovf      = ovf;

endmodule

// File: tb/tb_fifo_hex_drain.sv
// tb_fifo_hex_drain
// Drives fifo_hex_drain (LINE_BYTES=2) from a queue-based FIFO, checks every
// cycle against a transaction-level model of the expected character stream,
// and pins the model with literal character sequences for the directed cases.
module tb_fifo_hex_drain;
  localparam int LB = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_hex_drain_if bus();

  fifo_hex_drain #(.LINE_BYTES(LB)) dut (
    .i_clk  (clk),
    .i_res_n(rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] log_q[$];
  bit         rd_m, lat_m, ovf_m;
  int         cnt_m;
  int         ren_seen;
  logic       s_valid, s_ren, s_busy, s_ovf;
  logic [7:0] s_data;

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_log(input string name, input int n, input logic [63:0] seq);
    chk({name, "_len"}, log_q.size(), n);
    if (log_q.size() == n) begin
      for (int i = 0; i < n; i++) chk({name, "_char"}, log_q[i], seq[8*(n-1-i) +: 8]);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    bus.i_fifo_empty = 1'b0;
  endtask

  // One clock cycle: sample and compare at the falling edge, advance the model
  // to what the next rising edge must produce, then service the FIFO.
  task automatic tick();
    logic [7:0] b;
    bit         val_m, idle_m, pop_now;
    @(negedge clk);
    s_valid = bus.o_tx_valid;
    s_ren   = bus.o_fifo_ren;
    s_busy  = bus.o_busy;
    s_ovf   = bus.o_ovf;
    s_data  = bus.o_tx_data;
    if (!rst_n) begin
      chk("rst_valid", s_valid, 0);
      chk("rst_ren",   s_ren,   0);
      chk("rst_busy",  s_busy,  0);
      chk("rst_ovf",   s_ovf,   0);
      chk("rst_data",  s_data,  0);
      exp_q.delete();
      rd_m = 0; lat_m = 0; cnt_m = 0; ovf_m = 0;
    end else begin
      val_m  = (exp_q.size() != 0) && !lat_m;
      idle_m = !rd_m && !lat_m && (exp_q.size() == 0);
      chk("ren", s_ren, rd_m);
      chk("ren_while_empty", s_ren && bus.i_fifo_empty, 0);
      chk("busy", s_busy, !idle_m);
      chk("valid", s_valid, val_m);
      if (val_m) chk("tx_data", s_data, exp_q[0]);
      chk("ovf", s_ovf, ovf_m);
      if (s_ren) ren_seen++;
      if (s_valid && bus.i_tx_ready) log_q.push_back(s_data);
      if (bus.i_fifo_full) ovf_m = 1;
      else if (bus.i_ovf_clr) ovf_m = 0;
      if (rd_m) begin
        if (fifo_q.size() > 0) begin
          b = fifo_q[0];
          exp_q.push_back(hexc(b[7:4]));
          exp_q.push_back(hexc(b[3:0]));
          if (cnt_m == LB - 1) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
            cnt_m = 0;
          end else begin
            exp_q.push_back(8'h20);
            cnt_m++;
          end
        end
        rd_m  = 0;
        lat_m = 1;
      end else if (lat_m) begin
        lat_m = 0;
      end else if (val_m) begin
        if (bus.i_tx_ready) void'(exp_q.pop_front());
      end else if (bus.i_enable && !bus.i_fifo_empty) begin
        rd_m = 1;
      end else if (bus.i_flush && bus.i_fifo_empty && cnt_m != 0) begin
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        cnt_m = 0;
      end
    end
    pop_now = s_ren;
    @(posedge clk);
    #1;
    if (pop_now && fifo_q.size() > 0) bus.i_fifo_data = fifo_q.pop_front();
    bus.i_fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic flush_pulse();
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    int  first;
    bit  reached;
    int  n;
    bus.i_enable     = 1'b0;
    bus.i_flush      = 1'b0;
    bus.i_fifo_data  = 8'h00;
    bus.i_fifo_empty = 1'b1;
    bus.i_fifo_full  = 1'b0;
    bus.i_ovf_clr    = 1'b0;
    bus.i_tx_ready   = 1'b0;
    rd_m = 0; lat_m = 0; ovf_m = 0; cnt_m = 0; ren_seen = 0;

    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // single byte, latency and one read strobe
    bus.i_enable = 1'b1; bus.i_tx_ready = 1'b1;
    log_q.delete(); ren_seen = 0; first = -1;
    push(8'h3C);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (s_valid && first < 0) first = i;
    end
    chk("t1_latency", first, 3);
    chk("t1_ren_pulses", ren_seen, 1);
    chk_log("t1", 3, 64'h334320);

    // flush of a partial line, then a no-op flush
    log_q.delete();
    flush_pulse();
    chk_log("t2_flush", 2, 64'h0D0A);
    log_q.delete();
    flush_pulse();
    chk("t2_noop_len", log_q.size(), 0);
    chk("t2_noop_busy", s_busy, 0);

    // full line of two bytes
    log_q.delete();
    push(8'hA5); push(8'h0F);
    repeat (20) tick();
    chk_log("t3", 7, 64'h41352030460D0A);
    chk("t3_model_cnt", cnt_m, 0);
    log_q.delete();
    flush_pulse();
    chk("t3_cnt_zero_flush_len", log_q.size(), 0);

    // one byte then flush
    log_q.delete();
    push(8'h7F);
    repeat (10) tick();
    chk_log("t4_byte", 3, 64'h374620);
    log_q.delete();
    flush_pulse();
    chk_log("t4_flush", 2, 64'h0D0A);
    log_q.delete();
    flush_pulse();
    chk("t4_second_flush_len", log_q.size(), 0);

    // backpressure in HI
    bus.i_tx_ready = 1'b0;
    log_q.delete(); ren_seen = 0; reached = 0;
    push(8'hE1);
    for (int i = 0; i < 10 && !reached; i++) begin
      tick();
      if (s_valid) reached = 1;
    end
    chk("t5_reached_hi", reached, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_hold_data", s_data, 8'h45);
      chk("t5_hold_valid", s_valid, 1);
      chk("t5_no_ren", s_ren, 0);
    end
    bus.i_tx_ready = 1'b1;
    repeat (8) tick();
    chk_log("t5", 3, 64'h453120);
    chk("t5_ren_pulses", ren_seen, 1);
    flush_pulse();

    // overflow flag
    bus.i_fifo_full = 1'b1; tick(); bus.i_fifo_full = 1'b0; tick();
    chk("t6_set", s_ovf, 1);
    repeat (3) tick();
    chk("t6_held", s_ovf, 1);
    bus.i_fifo_full = 1'b1; bus.i_ovf_clr = 1'b1; tick();
    bus.i_fifo_full = 1'b0; bus.i_ovf_clr = 1'b0; tick();
    chk("t6_set_wins", s_ovf, 1);
    bus.i_ovf_clr = 1'b1; tick(); bus.i_ovf_clr = 1'b0; tick();
    chk("t6_clr", s_ovf, 0);

    // enable dropped during LO with more data queued
    bus.i_tx_ready = 1'b0;
    log_q.delete(); ren_seen = 0; reached = 0;
    push(8'h12); push(8'h34);
    for (int i = 0; i < 10 && !reached; i++) begin
      tick();
      if (s_valid) reached = 1;
    end
    chk("t7_reached_hi", reached, 1);
    bus.i_tx_ready = 1'b1; tick();
    bus.i_tx_ready = 1'b0; tick();
    chk("t7_in_lo", s_data, 8'h32);
    bus.i_enable = 1'b0; bus.i_tx_ready = 1'b1;
    repeat (12) tick();
    chk_log("t7", 3, 64'h313220);
    chk("t7_ren_pulses", ren_seen, 1);
    chk("t7_idle", s_busy, 0);
    chk("t7_fifo_left", fifo_q.size(), 1);

    // reset during CR; the next line starts from count 0
    bus.i_enable = 1'b1; reached = 0;
    for (int i = 0; i < 15 && !reached; i++) begin
      tick();
      if (s_valid && s_data == 8'h34) begin
        bus.i_tx_ready = 1'b0;
        reached = 1;
      end
    end
    chk("t8_reached_lo", reached, 1);
    tick();
    chk("t8_in_cr", s_data, 8'h0D);
    rst_n = 1'b0;
    #1;
    chk("t8_valid_drop", bus.o_tx_valid, 0);
    tick();
    chk("t8_rst_busy", s_busy, 0);
    rst_n = 1'b1; bus.i_tx_ready = 1'b1;
    log_q.delete();
    push(8'h56); push(8'h78);
    repeat (20) tick();
    chk_log("t8", 7, 64'h35362037380D0A);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0 && fifo_q.size() < 8) push(8'($urandom_range(255)));
      bus.i_enable    = ($urandom_range(9) != 0);
      bus.i_tx_ready  = ($urandom_range(9) < 7);
      bus.i_flush     = ($urandom_range(9) == 0);
      bus.i_fifo_full = ($urandom_range(49) == 0);
      bus.i_ovf_clr   = ($urandom_range(29) == 0);
      rst_n           = ($urandom_range(799) != 0);
      tick();
    end

    bus.i_enable = 1'b1; bus.i_tx_ready = 1'b1; bus.i_flush = 1'b0;
    bus.i_fifo_full = 1'b0; bus.i_ovf_clr = 1'b0; rst_n = 1'b1;
    n = 0;
    tick();
    while ((fifo_q.size() != 0 || s_busy) && n < 500) begin
      tick();
      n++;
    end
    chk("drain_timeout", n < 500, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_hex_drain.md
FIFO_HEX_DRAIN -- requirements
Module: fifo_hex_drain

Interface
REQ-001 The block SHALL have parameter LINE_BYTES, default 16, giving the number of bytes printed per text line (legal range 1..255).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 Port i_clk  input  1  rising-edge clock for all state.
REQ-004 Port i_res_n  input  1  asynchronous active-low reset.
REQ-005 Port i_enable  input  1  drain enable; when low, no new FIFO read is started.
REQ-006 Port i_flush  input  1  level request to terminate a partial line when the FIFO is empty.
REQ-007 Port o_fifo_ren  output  1  FIFO read strobe (FIFO data is registered and valid one cycle later).
REQ-008 Port i_fifo_data  input  8  FIFO read data.
REQ-009 Port i_fifo_empty  input  1  FIFO empty flag.
REQ-010 Port i_fifo_full  input  1  FIFO full flag (overflow detection).
REQ-011 Port i_ovf_clr  input  1  synchronous clear of o_ovf.
REQ-012 Port o_tx_data  output  8  ASCII character to the UART transmitter.
REQ-013 Port o_tx_valid  output  1  character valid.
REQ-014 Port i_tx_ready  input  1  transmitter accepts the character.
REQ-015 Port o_busy  output  1  high in every state except IDLE.
REQ-016 Port o_ovf  output  1  sticky "FIFO was full" flag.

Function
REQ-017 The FSM SHALL have the states IDLE, RD, LAT, HI, LO, SEP, CR and LF, all held in registers.
REQ-018 In IDLE, if i_enable=1 and i_fifo_empty=0, the next state SHALL be RD; else, if i_flush=1, i_fifo_empty=1 and the line count is nonzero, the next state SHALL be CR; else the FSM SHALL stay in IDLE.
REQ-019 o_fifo_ren SHALL be 1 exactly during the single RD cycle, and RD SHALL always go to LAT.
REQ-020 In LAT, i_fifo_data SHALL be captured into an 8-bit byte register, and the next state SHALL be HI.
REQ-021 In HI, LO, SEP, CR and LF, o_tx_valid SHALL be 1, and o_tx_data SHALL be held stable until a rising edge where i_tx_ready=1; the FSM SHALL advance only on that edge.
REQ-022 o_tx_valid SHALL be 0 in IDLE, RD and LAT.
REQ-023 HI SHALL send the ASCII hex of byte[7:4], and LO SHALL send the ASCII hex of byte[3:0], using nibble 0-9 -> 0x30+n and A-F -> 0x37+n (uppercase).
REQ-024 On LO acceptance, if the line count equals LINE_BYTES-1, the next state SHALL be CR; otherwise the line count SHALL increment and the next state SHALL be SEP.
REQ-025 SEP SHALL send 0x20, CR SHALL send 0x0D, and LF SHALL send 0x0A.
REQ-026 SEP and LF SHALL return to IDLE on acceptance, and LF acceptance SHALL zero the line count.
REQ-027 Latency: with i_enable=1, a FIFO going non-empty in IDLE at cycle n SHALL give RD at n+1, LAT at n+2, and o_tx_valid at n+3.
REQ-028 Back-to-back operation: with i_tx_ready held at 1, each byte SHALL take 6 cycles (IDLE, RD, LAT, HI, LO, SEP), and the last byte of a line SHALL take 7 cycles (IDLE, RD, LAT, HI, LO, CR, LF).
REQ-029 At most one FIFO read SHALL be outstanding, and o_fifo_ren SHALL never be asserted while i_fifo_empty=1.
REQ-030 Deasserting i_enable mid-sequence SHALL NOT abort the sequence: the current byte SHALL complete through SEP or LF, then the FSM SHALL hold in IDLE.
REQ-031 i_flush SHALL be ignored while the FIFO is non-empty and i_enable=1, since data takes priority; i_flush SHALL be a no-op when the line count is 0.
REQ-032 The line count SHALL be ceil(log2(LINE_BYTES+1)) bits wide and SHALL never exceed LINE_BYTES-1.
REQ-033 o_ovf SHALL be set on any cycle with i_fifo_full=1 and cleared on a cycle with i_ovf_clr=1; when both occur in the same cycle, set SHALL win.

Reset
REQ-034 While i_res_n=0, the state SHALL be IDLE, the line count and byte register SHALL be 0, and o_fifo_ren, o_tx_valid, o_busy and o_ovf SHALL all be 0.
REQ-035 o_tx_data SHALL reset to 0x00.
REQ-036 Reset asserted mid-character SHALL drop o_tx_valid immediately; after release, no partial character or line SHALL be resumed.

Verification
REQ-037 FIFO holds 0x3C, i_enable=1, i_tx_ready=1 -> tx sequence 0x33,0x43,0x20; exactly one o_fifo_ren pulse; o_tx_valid first high 3 cycles after IDLE sees non-empty.
REQ-038 LINE_BYTES=2, FIFO holds 0xA5,0x0F -> tx sequence "A5 0F\r\n" (0x41,0x35,0x20,0x30,0x46,0x0D,0x0A); line count returns to 0.
REQ-039 Backpressure: i_tx_ready low for 5 cycles during HI with byte 0xE1 -> o_tx_data stays 0x45 and o_tx_valid stays 1 for all 5 cycles; no extra FIFO read occurs.
REQ-040 One byte 0x7F printed, FIFO empty, i_flush=1 -> 0x0D,0x0A sent; a second i_flush pulse with count 0 -> no output.
REQ-041 i_fifo_full=1 for 1 cycle -> o_ovf=1 and held; i_ovf_clr and i_fifo_full high in the same cycle -> o_ovf stays 1; i_ovf_clr alone -> o_ovf=0.
REQ-042 i_enable dropped during LO of byte 0x12 with more data queued -> "2" then 0x20 sent, then IDLE with o_busy=0 and no o_fifo_ren; i_res_n pulsed during CR -> all outputs 0 and the next line starts at count 0.
